ma_stage: RTL and testbench

- Memory-access stage of the 5-stage RV32I pipeline. Consumes the EX/MA register outputs and performs data-memory loads and stores, including byte and halfword lane handling.
- Holds the MA/WB pipeline register and produces the write-back result and register-file write controls.
- Returns the two forwarding values consumed by the EX-stage operand muxes: MA-stage ALU result (select 01) and WB result (select 10).

---
 rtl/ma_stage.sv | 139 +++++++++++++
 tb/tb_ma_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// RV32I memory-access stage: data memory with byte/half lane handling, the MA/WB
// pipeline register, write-back mux and the two EX forwarding taps.
module ma_stage #(
    parameter int DMEM_WORDS = 1024,
    parameter int DMEM_AW    = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RegWEn_in,
    input  logic        MemRW_in,
    input  logic [1:0]  WBSel_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] ALU_Result_in,
    input  logic [31:0] DataB_in,
    input  logic [31:0] pcPlus4_in,
    input  logic [4:0]  AddrD_in,
    output logic [31:0] fwd_ALU_Result,
    output logic [31:0] WB_Result_out,
    output logic        RegWEn_out,
    output logic [4:0]  AddrD_out,
    output logic        misalign_err
);

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_PC4 = 2'b10;

    logic [31:0]        dmem [DMEM_WORDS];
    logic [DMEM_AW-1:0] word_idx;
    logic [1:0]         offset;
    logic [3:0]         byte_en;
    logic [31:0]        wdata;
    logic               store_mis;
    logic               load_mis;

    logic        wb_regwen;
    logic [4:0]  wb_addrd;
    logic [1:0]  wb_sel;
    logic [2:0]  wb_funct3;
    logic [1:0]  wb_off;
    logic [31:0] wb_alu;
    logic [31:0] wb_pc4;
    logic [31:0] wb_rdata;
    logic [7:0]  wb_byte;
    logic [15:0] wb_half;
    logic [31:0] load_val;
    logic        wb_mis;

    assign word_idx       = ALU_Result_in[DMEM_AW+1:2];
    assign offset         = ALU_Result_in[1:0];
    assign fwd_ALU_Result = ALU_Result_in;

    always_comb begin
        byte_en   = 4'b0000;
        wdata     = DataB_in;
        store_mis = 1'b0;
        case (funct3_in)
            3'b000: begin
                byte_en = 4'b0001 << offset;
                wdata   = {4{DataB_in[7:0]}};
            end
            3'b001: begin
                wdata = {2{DataB_in[15:0]}};
                if (offset[0]) store_mis = 1'b1;
                else           byte_en   = offset[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                if (offset != 2'b00) store_mis = 1'b1;
                else                 byte_en   = 4'b1111;
            end
            default: ;
        endcase
    end

    // Load misalignment is detected here so the sticky flag rises in the WB cycle.
    assign load_mis = (WBSel_in == WB_MEM) &&
                      (((funct3_in[1:0] == 2'b01) && offset[0]) ||
                       ((funct3_in == 3'b010) && (offset != 2'b00)));

    // Write commits at this edge, so a load of the same word next cycle sees it.
    always_ff @(posedge clk) begin
        if (reset_n && MemRW_in) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) dmem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        wb_rdata <= dmem[word_idx];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_regwen    <= 1'b0;
            wb_addrd     <= 5'd0;
            wb_sel       <= 2'b01;
            wb_funct3    <= 3'b000;
            wb_off       <= 2'b00;
            wb_alu       <= 32'd0;
            wb_pc4       <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            wb_regwen <= RegWEn_in;
            wb_addrd  <= AddrD_in;
            wb_sel    <= WBSel_in;
            wb_funct3 <= funct3_in;
            wb_off    <= offset;
            wb_alu    <= ALU_Result_in;
            wb_pc4    <= pcPlus4_in;
            if ((MemRW_in && store_mis) || load_mis) misalign_err <= 1'b1;
        end
    end

    assign wb_byte = wb_rdata[8*wb_off +: 8];
    assign wb_half = wb_off[1] ? wb_rdata[31:16] : wb_rdata[15:0];
    assign wb_mis  = ((wb_funct3[1:0] == 2'b01) && wb_off[0]) ||
                     ((wb_funct3 == 3'b010) && (wb_off != 2'b00));

    always_comb begin
        load_val = 32'd0;
        case (wb_funct3)
            3'b000:  load_val = {{24{wb_byte[7]}}, wb_byte};
            3'b100:  load_val = {24'd0, wb_byte};
            3'b001:  load_val = {{16{wb_half[15]}}, wb_half};
            3'b101:  load_val = {16'd0, wb_half};
            3'b010:  load_val = wb_rdata;
            default: load_val = 32'd0;
        endcase
    end

    always_comb begin
        case (wb_sel)
            WB_MEM:  WB_Result_out = load_val;
            WB_PC4:  WB_Result_out = wb_pc4;
            default: WB_Result_out = wb_alu;
        endcase
    end

    assign AddrD_out  = wb_addrd;
    assign RegWEn_out = wb_regwen && (wb_addrd != 5'd0) && !((wb_sel == WB_MEM) && wb_mis);

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: vector table driven through a one-deep
// scoreboard queue, plus reset and misalignment sequences.
module tb_ma_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        RegWEn_in;
    logic        MemRW_in;
    logic [1:0]  WBSel_in;
    logic [2:0]  funct3_in;
    logic [31:0] ALU_Result_in;
    logic [31:0] DataB_in;
    logic [31:0] pcPlus4_in;
    logic [4:0]  AddrD_in;
    logic [31:0] fwd_ALU_Result;
    logic [31:0] WB_Result_out;
    logic        RegWEn_out;
    logic [4:0]  AddrD_out;
    logic        misalign_err;

    int vectors = 0;
    int miscompares = 0;

    // mode: 0 = result not checked, 1 = must equal, 2 = must differ
    typedef struct {
        logic        regwen;
        logic        memrw;
        logic [1:0]  wbsel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] datab;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [1:0]  mode;
        logic [31:0] exp_res;
        logic        exp_we;
        logic        exp_mis;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    ma_stage #(.DMEM_WORDS(1024), .DMEM_AW(10)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .RegWEn_in     (RegWEn_in),
        .MemRW_in      (MemRW_in),
        .WBSel_in      (WBSel_in),
        .funct3_in     (funct3_in),
        .ALU_Result_in (ALU_Result_in),
        .DataB_in      (DataB_in),
        .pcPlus4_in    (pcPlus4_in),
        .AddrD_in      (AddrD_in),
        .fwd_ALU_Result(fwd_ALU_Result),
        .WB_Result_out (WB_Result_out),
        .RegWEn_out    (RegWEn_out),
        .AddrD_out     (AddrD_out),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic regwen, input logic memrw, input logic [1:0] wbsel,
                                input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] datab,
                                input logic [31:0] pc4, input logic [4:0] rd, input logic [1:0] mode,
                                input logic [31:0] exp_res, input logic exp_we, input logic exp_mis);
        vec_t v;
        v.regwen = regwen; v.memrw = memrw; v.wbsel = wbsel; v.f3 = f3;
        v.alu = alu; v.datab = datab; v.pc4 = pc4; v.rd = rd;
        v.mode = mode; v.exp_res = exp_res; v.exp_we = exp_we; v.exp_mis = exp_mis;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        RegWEn_in = 1'b0; MemRW_in = 1'b0; WBSel_in = 2'b01; funct3_in = 3'b000;
        ALU_Result_in = 32'd0; DataB_in = 32'd0; pcPlus4_in = 32'd0; AddrD_in = 5'd0;
    endtask

    task automatic applyStimulus(input vec_t v);
        RegWEn_in = v.regwen; MemRW_in = v.memrw; WBSel_in = v.wbsel; funct3_in = v.f3;
        ALU_Result_in = v.alu; DataB_in = v.datab; pcPlus4_in = v.pc4; AddrD_in = v.rd;
        sb.push_back(v);
        #1;
        check32("fwd_ALU_Result", fwd_ALU_Result, v.alu);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard: got empty queue, required one entry");
            return;
        end
        e = sb.pop_front();
        if (e.mode == 2'd1) check32("WB_Result_out", WB_Result_out, e.exp_res);
        if (e.mode == 2'd2) begin
            vectors++;
            if (WB_Result_out === e.exp_res) begin
                miscompares++;
                $display("[TB] FAIL WB_Result_out_ne: got 0x%08h, required anything else", WB_Result_out);
            end
        end
        check32("RegWEn_out", {31'd0, RegWEn_out}, {31'd0, e.exp_we});
        check32("AddrD_out", {27'd0, AddrD_out}, {27'd0, e.rd});
        check32("misalign_err", {31'd0, misalign_err}, {31'd0, e.exp_mis});
    endtask

    task automatic runVec(input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Reset with a store to 0x10 presented, which must not reach memory.
    task automatic doReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            reset_n = 1'b0;
            RegWEn_in = 1'b1; MemRW_in = 1'b1; WBSel_in = 2'b10; funct3_in = 3'b010;
            ALU_Result_in = 32'h10; DataB_in = 32'hDEADBEEF; pcPlus4_in = 32'h44; AddrD_in = 5'd12;
            @(posedge clk);
            #1;
            check32("reset_WB_Result_out", WB_Result_out, 32'd0);
            check32("reset_RegWEn_out", {31'd0, RegWEn_out}, 32'd0);
            check32("reset_AddrD_out", {27'd0, AddrD_out}, 32'd0);
            check32("reset_misalign_err", {31'd0, misalign_err}, 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idleInputs();
    endtask

    initial begin
        reset_n = 1'b0;
        idleInputs();
        doReset(2);

        // regwen memrw wbsel f3 alu datab pc4 rd mode exp_res exp_we exp_mis
        tbl.push_back(mk(0, 1, 2'b01, 3'b010, 32'h20, 32'h12345678, 0, 0, 1, 32'h20, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b010, 32'h20, 0, 0, 5, 1, 32'h12345678, 1, 0));
        tbl.push_back(mk(0, 1, 2'b01, 3'b010, 32'h40, 32'h0, 0, 0, 1, 32'h40, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 3'b000, 32'h43, 32'h11223380, 0, 0, 1, 32'h43, 0, 0));
        tbl.push_back(mk(0, 1, 2'b01, 3'b001, 32'h40, 32'h1234BEEF, 0, 0, 1, 32'h40, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b010, 32'h40, 0, 0, 1, 1, 32'h8000BEEF, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b000, 32'h43, 0, 0, 2, 1, 32'hFFFFFF80, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b100, 32'h43, 0, 0, 2, 1, 32'h00000080, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b001, 32'h40, 0, 0, 3, 1, 32'hFFFFBEEF, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b101, 32'h40, 0, 0, 3, 1, 32'h0000BEEF, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b001, 32'h42, 0, 0, 4, 1, 32'hFFFF8000, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b101, 32'h42, 0, 0, 4, 1, 32'h00008000, 1, 0));
        tbl.push_back(mk(0, 1, 2'b01, 3'b010, 32'h80, 32'hA5A5A5A5, 0, 0, 1, 32'h80, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b010, 32'h80, 0, 0, 9, 1, 32'hA5A5A5A5, 1, 0));
        tbl.push_back(mk(1, 0, 2'b10, 3'b000, 32'h55, 0, 32'h104, 3, 1, 32'h104, 1, 0));
        tbl.push_back(mk(1, 0, 2'b01, 3'b000, 32'h77, 0, 32'h8, 0, 1, 32'h77, 0, 0));
        tbl.push_back(mk(1, 0, 2'b11, 3'b000, 32'hCAFE0000, 0, 32'h8, 4, 1, 32'hCAFE0000, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b010, 32'h10, 0, 0, 6, 2, 32'hDEADBEEF, 1, 0));
        tbl.push_back(mk(0, 1, 2'b01, 3'b010, 32'h1004, 32'h0BADF00D, 0, 0, 1, 32'h1004, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b010, 32'h4, 0, 0, 11, 1, 32'h0BADF00D, 1, 0));
        tbl.push_back(mk(1, 0, 2'b00, 3'b011, 32'h4, 0, 0, 8, 1, 32'h0, 1, 0));

        foreach (tbl[i]) runVec(tbl[i]);

        // Misaligned store: suppressed, flag sticky until reset.
        runVec(mk(0, 1, 2'b01, 3'b010, 32'h60, 32'h11111111, 0, 0, 1, 32'h60, 0, 0));
        runVec(mk(0, 1, 2'b01, 3'b010, 32'h61, 32'hFFFFFFFF, 0, 0, 1, 32'h61, 0, 1));
        runVec(mk(1, 0, 2'b00, 3'b010, 32'h60, 0, 0, 10, 1, 32'h11111111, 1, 1));
        runVec(mk(0, 0, 2'b01, 3'b000, 32'h0, 0, 0, 0, 1, 32'h0, 0, 1));
        doReset(1);

        // Misaligned load: write enable dropped, flag raised.
        runVec(mk(1, 0, 2'b00, 3'b001, 32'h63, 0, 0, 7, 0, 32'h0, 0, 1));
        runVec(mk(0, 0, 2'b01, 3'b000, 32'h0, 0, 0, 0, 1, 32'h0, 0, 1));
        doReset(1);

        check32("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
